sram_axi_bridge: RTL and testbench

Converts the CPU core's two SRAM-like request ports (instruction fetch, data memory) into a single AXI3 master interface. It sits directly downstream of the pipeline datapath, between the core's `pcF`/`inst_enF` and `mem_*M` ports and the SoC AXI interconnect. It serialises one outstanding transaction at a time, arbitrates data over instruction, and returns `addr_ok`/`data_ok` handshakes that the core's hazard unit turns into stalls.

---
 rtl/axi_bridge_pkg.sv | 36 +++
 rtl/axi_wstrb_gen.sv | 30 +++
 rtl/sram_axi_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_bridge_pkg
// Description : Shared types and constants for the SRAM-to-AXI3 bridge.
//               Holds the bridge FSM state encoding, the AXI IDs used for
//               the two request sources, the burst type and the SRAM-side
//               transfer-size encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4
    } state_e;

    localparam logic [3:0] AXI_ID_INST    = 4'd0;
    localparam logic [3:0] AXI_ID_DATA    = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // SRAM-side size encodings (bytes = 1 << size)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    // Size 3 has no meaning on a 32-bit bus; fold it onto a full word.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_RSVD) ? SIZE_WORD : size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wstrb_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_wstrb_gen
// Description : Combinational AXI write-strobe generator for a 32-bit bus.
//               Byte and halfword strobes are shifted to the lane selected
//               by the low address bits; words enable all four lanes.
// Ports       : size_i    - normalised transfer size (0 byte,1 half,2 word)
//               addr_lo_i - address bits [1:0]
//               wstrb_o   - byte-lane write strobes
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wstrb_gen
    import axi_bridge_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    always_comb begin
        wstrb_o = 4'b1111;
        case (size_i)
            SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
            SIZE_HALF: wstrb_o = 4'b0011 << addr_lo_i;
            default:   wstrb_o = 4'b1111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_bridge
// Description : Bridges the core's instruction and data SRAM-like ports onto
//               a single AXI3 master. One transaction is in flight at a time;
//               data requests win over instruction requests.
// Ports       : clk/resetn          - clock, asynchronous active-low reset
//               inst_* / data_*     - SRAM-like request/response ports
//               ar*/r*/aw*/w*/b*    - AXI3 master channels
// Config      : AXI_POSTED_WRITE_EN - when defined, data_data_ok for a write
//               is returned once both AW and W have handshaken instead of
//               waiting for the B response (the FSM still waits for B).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_bridge
    import axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // instruction port
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    // data port
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    // AR channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // R channel
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AW channel
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // W channel
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B channel
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [1:0]        size_q,  size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              src_data_q, src_data_d;   // 1: data port, 0: inst port
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              unused_inputs;

    // Response fields and inst_wr carry no information for this bridge.
    assign unused_inputs = ^{inst_wr, rid, rresp, rlast, bid, bresp};

    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid & wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            src_data_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            src_data_q <= src_data_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        src_data_d   = src_data_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    addr_d       = data_addr;
                    size_d       = norm_size(data_size);
                    wdata_d      = data_wdata;
                    src_data_d   = 1'b1;
                    state_d      = data_wr ? ST_WR_ADDR : ST_RD_ADDR;
                end else if (inst_req) begin
                    // Instruction port is read-only regardless of inst_wr.
                    inst_addr_ok = 1'b1;
                    addr_d       = inst_addr;
                    size_d       = norm_size(inst_size);
                    wdata_d      = inst_wdata;
                    src_data_d   = 1'b0;
                    state_d      = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rvalid) begin
                    if (src_data_q) begin
                        data_data_ok = 1'b1;
                    end else begin
                        inst_data_ok = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                // AW and W complete independently; leave once both have.
                aw_done_d = aw_done_q | w_aw_hs;
                w_done_d  = w_done_q  | w_w_hs;
                if ((aw_done_q | w_aw_hs) && (w_done_q | w_w_hs)) begin
                    state_d   = ST_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AXI_POSTED_WRITE_EN
                    data_data_ok = 1'b1;
`else
                    data_data_ok = 1'b0;
`endif
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    state_d = ST_IDLE;
`ifdef AXI_POSTED_WRITE_EN
                    data_data_ok = 1'b0;
`else
                    data_data_ok = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is forwarded straight from the R channel in its valid cycle.
    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    assign arid    = src_data_q ? AXI_ID_DATA : AXI_ID_INST;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == ST_RD_ADDR);
    assign rready  = (state_q == ST_RD_DATA);

    assign awid    = AXI_ID_DATA;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (state_q == ST_WR_ADDR) & ~aw_done_q;

    assign wid     = AXI_ID_DATA;
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == ST_WR_ADDR) & ~w_done_q;
    assign bready  = (state_q == ST_WR_RESP);

    axi_wstrb_gen u_wstrb_gen (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wstrb_o   (wstrb)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_axi_bridge
// Description : Self-checking bench for sram_axi_bridge. A table of single
//               transactions (reads from either port, writes of each size)
//               is replayed against a scripted AXI slave, followed by
//               hand-written sequences for arbitration and mid-transaction
//               reset. AXI_POSTED_WRITE_EN selects the expected write
//               completion point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_axi_bridge;

`ifdef AXI_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        bit          wr;
        bit          is_data;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  exp_strb;
        logic [2:0]  exp_axsize;
        logic [3:0]  exp_id;
        int          wdelay;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input vec_t v);
        if (v.is_data) begin
            data_req = 1'b1; data_wr = 1'b0; data_addr = v.addr; data_size = v.size;
        end else begin
            inst_req = 1'b1; inst_wr = v.wr; inst_addr = v.addr; inst_size = v.size;
        end
        #1;
        chk("rd_addr_ok", v.is_data ? data_addr_ok : inst_addr_ok, 1);
        chk("rd_other_addr_ok", v.is_data ? inst_addr_ok : data_addr_ok, 0);
        next_cycle();
        inst_req = 1'b0; inst_wr = 1'b0; data_req = 1'b0; arready = 1'b1;
        #1;
        chk("rd_arvalid", arvalid, 1);
        chk("rd_awvalid", awvalid, 0);
        chk("rd_araddr", araddr, v.addr);
        chk("rd_arid", arid, v.exp_id);
        chk("rd_arsize", arsize, v.exp_axsize);
        chk("rd_arlen", arlen, 0);
        chk("rd_arburst", arburst, 2'b01);
        next_cycle();
        arready = 1'b0; rvalid = 1'b1; rdata = v.rd;
        #1;
        chk("rd_rready", rready, 1);
        chk("rd_data_ok", v.is_data ? data_data_ok : inst_data_ok, 1);
        chk("rd_other_data_ok", v.is_data ? inst_data_ok : data_data_ok, 0);
        chk("rd_rdata", v.is_data ? data_rdata : inst_rdata, v.rd);
        next_cycle();
        rvalid = 1'b0;
        #1;
        chk("rd_rready_after", rready, 0);
        chk("rd_data_ok_after", v.is_data ? data_data_ok : inst_data_ok, 0);
    endtask

    task automatic do_write(input vec_t v);
        int okc;
        okc = 0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = v.addr;
        data_size = v.size; data_wdata = v.wd;
        #1;
        chk("wr_addr_ok", data_addr_ok, 1);
        next_cycle();
        data_req = 1'b0; data_wr = 1'b0;
        for (int k = 1; k <= 1 + v.wdelay; k++) begin
            awready = (k == 1);
            wready  = (k == 1 + v.wdelay);
            #1;
            chk("wr_awvalid", awvalid, (k == 1));
            chk("wr_wvalid", wvalid, 1);
            chk("wr_data_ok_aw", data_data_ok, (POSTED && (k == 1 + v.wdelay)));
            if (k == 1) begin
                chk("wr_awaddr", awaddr, v.addr);
                chk("wr_awsize", awsize, v.exp_axsize);
                chk("wr_wstrb", wstrb, v.exp_strb);
                chk("wr_wdata", wdata, v.wd);
                chk("wr_wlast", wlast, 1);
                chk("wr_awid", awid, 1);
            end
            if (data_data_ok) okc++;
            next_cycle();
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        chk("wr_awvalid_b", awvalid, 0);
        chk("wr_wvalid_b", wvalid, 0);
        chk("wr_bready", bready, 1);
        chk("wr_data_ok_b", data_data_ok, !POSTED);
        if (data_data_ok) okc++;
        next_cycle();
        bvalid = 1'b0;
        #1;
        chk("wr_bready_after", bready, 0);
        chk("wr_data_ok_count", okc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            wr  dat addr          sz    wdata         rdata         strb     axsz  id    dly
        vecs[0] = '{1'b0, 1'b0, 32'hBFC00000, 2'd2, 32'h0,        32'h3C010001, 4'b0000, 3'd2, 4'd0, 0};
        vecs[1] = '{1'b0, 1'b1, 32'h80000010, 2'd2, 32'h0,        32'h12345678, 4'b0000, 3'd2, 4'd1, 0};
        vecs[2] = '{1'b1, 1'b1, 32'h80000003, 2'd0, 32'hAB000000, 32'h0,        4'b1000, 3'd0, 4'd1, 0};
        vecs[3] = '{1'b1, 1'b1, 32'h80000002, 2'd1, 32'hCDEF0000, 32'h0,        4'b1100, 3'd1, 4'd1, 0};
        vecs[4] = '{1'b1, 1'b1, 32'h80000001, 2'd0, 32'h00005A00, 32'h0,        4'b0010, 3'd0, 4'd1, 0};
        vecs[5] = '{1'b1, 1'b1, 32'h80000004, 2'd3, 32'hDEADBEEF, 32'h0,        4'b1111, 3'd2, 4'd1, 0};
        vecs[6] = '{1'b1, 1'b1, 32'h80000100, 2'd2, 32'hCAFEF00D, 32'h0,        4'b1111, 3'd2, 4'd1, 3};
        vecs[7] = '{1'b1, 1'b0, 32'h00001002, 2'd1, 32'h0,        32'hA5A5A5A5, 4'b0000, 3'd1, 4'd0, 0};
        vecs[8] = '{1'b0, 1'b1, 32'h80000007, 2'd0, 32'h0,        32'h000000EE, 4'b0000, 3'd0, 4'd1, 0};

        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rid = 4'hF; rresp = 2'b10; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bid = 4'hF; bresp = 2'b10;

        // Reset state
        next_cycle();
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_wdata", wdata, 0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // Table of single transactions
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr && vecs[i].is_data) do_write(vecs[i]);
            else                               do_read(vecs[i]);
            next_cycle();
        end

        // Simultaneous inst and data requests: data served first
        inst_req = 1; inst_addr = 32'hBFC00040; inst_size = 2'd2;
        data_req = 1; data_wr = 0; data_addr = 32'h80000010; data_size = 2'd2;
        #1;
        chk("arb_data_addr_ok", data_addr_ok, 1);
        chk("arb_inst_addr_ok", inst_addr_ok, 0);
        next_cycle();
        data_req = 0; arready = 1;
        #1;
        chk("arb_arid_data", arid, 1);
        chk("arb_araddr_data", araddr, 32'h80000010);
        chk("arb_inst_wait1", inst_addr_ok, 0);
        next_cycle();
        arready = 0; rvalid = 1; rdata = 32'h0BADF00D;
        #1;
        chk("arb_data_data_ok", data_data_ok, 1);
        chk("arb_inst_wait2", inst_addr_ok, 0);
        next_cycle();
        rvalid = 0;
        #1;
        chk("arb_inst_addr_ok_now", inst_addr_ok, 1);
        next_cycle();
        inst_req = 0; arready = 1;
        #1;
        chk("arb_arid_inst", arid, 0);
        chk("arb_araddr_inst", araddr, 32'hBFC00040);
        next_cycle();
        arready = 0; rvalid = 1; rdata = 32'h24020001;
        #1;
        chk("arb_inst_data_ok", inst_data_ok, 1);
        chk("arb_inst_rdata", inst_rdata, 32'h24020001);
        next_cycle();
        rvalid = 0;
        next_cycle();

        // Reset while waiting in RD_DATA
        inst_req = 1; inst_addr = 32'hBFC00080; inst_size = 2'd2;
        next_cycle();
        inst_req = 0; arready = 1;
        next_cycle();
        arready = 0;
        #1;
        chk("rstm_rready_before", rready, 1);
        #2;
        resetn = 0;
        #1;
        chk("rstm_rready", rready, 0);
        chk("rstm_arvalid", arvalid, 0);
        rvalid = 1; rdata = 32'hFFFFFFFF;
        #1;
        chk("rstm_no_data_ok", inst_data_ok, 0);
        next_cycle();
        next_cycle();
        rvalid = 0;
        resetn = 1;
        #1;
        chk("rstm_idle_arvalid", arvalid, 0);
        chk("rstm_idle_rready", rready, 0);
        next_cycle();
        do_read(vecs[0]);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
